// File: rtl/glb_reader_if.sv
// Command, GLB read port and output word stream of the GLB reader.
// master = the controlling environment; slave = the reader itself.
interface glb_reader_if;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic [15:0] stride;
  logic        busy;
  logic        done;
  logic [3:0]  glb_w_en;
  logic [15:0] glb_address;
  logic [31:0] glb_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output start, base_addr, word_count, stride, glb_read_data, out_ready,
    input  busy, done, glb_w_en, glb_address, out_valid, out_data, out_last
  );

  modport slave (
    input  start, base_addr, word_count, stride, glb_read_data, out_ready,
    output busy, done, glb_w_en, glb_address, out_valid, out_data, out_last
  );
endinterface

// File: rtl/glb_reader.sv
// Strided GLB word reader streaming over ready/valid; stride honoured only with GLB_READER_STRIDE_EN.
// First read 1 cycle after start, first beat 1 cycle later; reads stall on out_ready via FIFO credits.
module glb_reader #(
  parameter int FIFO_DEPTH = 2  // must be >= 2
) (
  input logic         clk,
  input logic         rst,
  glb_reader_if.slave bus
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     issue_left_q, issue_left_d;
  logic [15:0]     beats_left_q, beats_left_d;
  logic [15:0]     next_addr_q, next_addr_d;
  logic [15:0]     addr_q, addr_d;
  logic            rd_vld_q, rd_vld_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [15:0]     inc;

  logic start_acc, issue, fifo_empty, out_valid, out_last, beat, push, pop;

  assign start_acc = (state_q == IDLE) && bus.start;

`ifdef GLB_READER_STRIDE_EN
  logic [15:0] stride_q, stride_d;
  assign stride_d = start_acc ? bus.stride : stride_q;
  assign inc      = stride_q;
  always_ff @(posedge clk) begin
    if (rst) stride_q <= '0;
    else     stride_q <= stride_d;
  end
`else
  logic unused_stride;
  assign unused_stride = ^bus.stride;
  assign inc           = 16'd4;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Returning read data is offered straight to the consumer while the FIFO is
  // empty, so the first beat appears the cycle the data comes back.
  assign fifo_empty = (count_q == '0);
  assign out_valid  = !fifo_empty || rd_vld_q;
  assign out_last   = out_valid && (beats_left_q == 16'd1);
  assign beat       = out_valid && bus.out_ready;
  assign pop        = !fifo_empty && bus.out_ready;
  assign push       = rd_vld_q && !(fifo_empty && bus.out_ready);
  assign issue      = (state_q == RUN) && (issue_left_q != 16'd0) &&
                      ((int'(count_q) + int'(rd_vld_q)) < FIFO_DEPTH);

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.glb_w_en    = 4'b0000;
  assign bus.glb_address = issue ? next_addr_q : addr_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_last    = out_last;
  assign bus.out_data    = !fifo_empty ? mem_q[rd_ptr_q] :
                           (rd_vld_q ? bus.glb_read_data : 32'd0);

  always_comb begin
    state_d      = state_q;
    issue_left_d = issue_left_q;
    beats_left_d = beats_left_q;
    next_addr_d  = next_addr_q;
    addr_d       = addr_q;
    rd_vld_d     = issue;
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          issue_left_d = bus.word_count;
          beats_left_d = bus.word_count;
          next_addr_d  = bus.base_addr;
          state_d      = (bus.word_count == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d       = next_addr_q;
          next_addr_d  = next_addr_q + inc;
          issue_left_d = issue_left_q - 16'd1;
        end
        if (beat) begin
          beats_left_d = beats_left_q - 16'd1;
          if (out_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_left_q <= '0;
      beats_left_q <= '0;
      next_addr_q  <= '0;
      addr_q       <= '0;
      rd_vld_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      beats_left_q <= beats_left_d;
      next_addr_q  <= next_addr_d;
      addr_q       <= addr_d;
      rd_vld_q     <= rd_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.glb_read_data;
  end

endmodule

// File: tb/tb_glb_reader.sv
// Randomized bench for glb_reader against a transfer-level model of addresses and beats.
module tb_glb_reader;
  localparam int DEPTH = 2;
`ifdef GLB_READER_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  glb_reader_if bus();

  glb_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] seed;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] glb_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, a + seed};
  endfunction

  function automatic logic [15:0] step_of(input logic [15:0] s);
    return STRIDE_EN ? s : 16'd4;
  endfunction

  function automatic logic [15:0] addr_at(input logic [15:0] base, input logic [15:0] s, input int i);
    return 16'(32'(base) + i * 32'(step_of(s)));
  endfunction

  // GLB memory: data for the address seen in a cycle appears in the next cycle.
  initial begin : glb_mem
    logic [15:0] a;
    bus.glb_read_data = '0;
    forever begin
      @(negedge clk);
      a = bus.glb_address;
      @(posedge clk);
      #1;
      bus.glb_read_data = glb_word(a);
    end
  end

  task automatic check_reset_vals();
    check_eq("rst_busy",      bus.busy,        0);
    check_eq("rst_done",      bus.done,        0);
    check_eq("rst_out_valid", bus.out_valid,   0);
    check_eq("rst_out_last",  bus.out_last,    0);
    check_eq("rst_out_data",  bus.out_data,    0);
    check_eq("rst_glb_addr",  bus.glb_address, 0);
    check_eq("rst_glb_w_en",  bus.glb_w_en,    0);
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'(($urandom & 32'h3) != 0);
    endcase
  endfunction

  // One transfer; called at #1 after a rising edge with the block in IDLE.
  task automatic xfer(input logic [15:0] base, input int wc, input logic [15:0] strd, input int mode);
    int          cyc = 0, beats = 0, last_cyc = 0;
    int          limit = 6 * wc + 20;
    bit          fin = 0;
    logic        prev_v = 0, prev_r = 0;
    logic [31:0] prev_d = '0;
    logic [15:0] idle_addr = '0;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = 16'(wc);
    bus.stride     = strd;
    while (!fin && cyc <= limit) begin
      bus.out_ready = ready_pat(mode, cyc);
      if (cyc == 3) begin
        // Start while RUN/DONE must be ignored.
        bus.start      = 1'b1;
        bus.base_addr  = 16'($urandom);
        bus.word_count = 16'($urandom_range(0, 5));
        bus.stride     = 16'($urandom);
      end else if (cyc > 0) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) begin
        check_eq("idle_busy", bus.busy, 0);
        idle_addr = bus.glb_address;
      end else begin
        if (cyc == 1 && wc == 0) begin
          check_eq("zero_addr_hold", bus.glb_address, idle_addr);
          check_eq("zero_no_valid",  bus.out_valid,   0);
        end
        if (cyc == 1 && wc != 0) check_eq("first_valid_late", bus.out_valid, 0);
        if (cyc == 2 && wc != 0) check_eq("first_valid", bus.out_valid, 1);
        if (mode == 0 && cyc <= wc)
          check_eq("addr_seq", bus.glb_address, addr_at(base, strd, cyc - 1));
        if (prev_v && !prev_r) begin
          check_eq("stall_valid", bus.out_valid, 1);
          check_eq("stall_data",  bus.out_data,  prev_d);
        end
        if (bus.out_valid && bus.out_ready) begin
          check_eq("beat_data", bus.out_data, glb_word(addr_at(base, strd, beats)));
          check_eq("beat_last", bus.out_last, 32'(beats == wc - 1));
          if (mode == 0) check_eq("beat_cycle", cyc, beats + 2);
          beats++;
          last_cyc = cyc;
        end
        if (bus.done) begin
          check_eq("done_cycle",   cyc, (wc == 0) ? 1 : last_cyc + 1);
          check_eq("beat_count",   beats, wc);
          check_eq("busy_in_done", bus.busy, 0);
          fin = 1;
        end else if (wc != 0) begin
          check_eq("busy_in_run", bus.busy, 1);
        end
      end
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = bus.out_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("done_seen", 32'(fin), 1);
    bus.start = 1'b0;
    @(negedge clk);
    check_eq("done_pulse", bus.done, 0);
    check_eq("idle_after", bus.busy, 0);
    check_eq("w_en_zero",  bus.glb_w_en, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid();
    int beats = 0;
    int cyc   = 0;
    bus.start      = 1'b1;
    bus.base_addr  = 16'h0500;
    bus.word_count = 16'd8;
    bus.stride     = 16'd4;
    bus.out_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (beats < 2 && cyc < 20) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) beats++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("rst_mid_beats", beats, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.stride     = '0;
    bus.out_ready  = 1'b0;
    seed           = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b0;

    xfer(16'h0100, 4, 16'd4,  0);  // contiguous burst
    xfer(16'h0040, 8, 16'd4,  1);  // backpressure 1,0,0
    xfer(16'h1234, 0, 16'd4,  0);  // zero count
    xfer(16'hFFF8, 4, 16'd4,  0);  // address wrap
    xfer(16'h0200, 4, 16'd16, 0);  // stride
    reset_mid();
    xfer(16'h0300, 3, 16'd8,  0);  // start accepted after reset
    for (int i = 0; i < 10; i++)
      xfer(16'($urandom), $urandom_range(1, 12), 16'($urandom_range(0, 64)), $urandom_range(0, 2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/glb_reader.md
GLB_READER -- requirements
Module: glb_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of output buffer entries; SHALL be at least 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  transfer request pulse; sampled only in IDLE.
REQ-005 base_addr  input  16  byte address of the first word; captured when start is accepted.
REQ-006 word_count  input  16  number of 32-bit words to read; captured when start is accepted.
REQ-007 stride  input  16  byte increment between words; captured when start is accepted.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 glb_w_en  output  4  GLB byte write enables; SHALL be tied to 4'b0000.
REQ-011 glb_address  output  16  GLB byte address of the current read.
REQ-012 glb_read_data  input  32  GLB read data; valid exactly 1 cycle after the address was presented.
REQ-013 out_valid / out_ready / out_data[31:0] / out_last  output / input / output / output  ready-valid stream of words read.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
- IDLE -> RUN: start=1 with word_count!=0.
- IDLE -> DONE: start=1 with word_count=0, with no GLB reads and no output beats.
- RUN -> DONE: the beat carrying out_last handshakes.
- DONE -> IDLE: unconditionally after 1 cycle.
REQ-015 done SHALL be high only in DONE; busy SHALL be high only in RUN.
REQ-016 start SHALL be ignored in RUN and DONE.
REQ-017 A read SHALL be issued in a RUN cycle only when all of the following hold: words remain to be issued, and FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
REQ-018 The word returned 1 cycle after issue SHALL be written into the FIFO; the FIFO SHALL never overflow.
REQ-019 Read addresses SHALL be base_addr, base_addr+stride, base_addr+2*stride, ..., computed modulo 2^16 (wrap from 0xFFFF to 0x0000, no error).
REQ-020 glb_address SHALL hold its last value when no read is issued.
REQ-021 out_valid SHALL be high whenever the FIFO is non-empty; out_data SHALL be the FIFO head.
REQ-022 A beat transfers when out_valid=1 and out_ready=1.
REQ-023 out_valid and out_data SHALL remain stable while out_ready=0.
REQ-024 out_last SHALL be high exactly on the word_count-th beat.
REQ-025 Latency: start accepted at edge T -> first read issued in cycle T+1 -> first out_valid in cycle T+2.
REQ-026 With out_ready held high, throughput SHALL be 1 word per cycle with no bubbles.
REQ-027 Simultaneous FIFO push and pop in one cycle SHALL leave occupancy unchanged.

Reset
REQ-028 rst=1 at a clock edge SHALL return the block to IDLE, including mid-transfer.
REQ-029 Reset SHALL empty the FIFO and discard in-flight reads; the in-flight read data SHALL be dropped.
REQ-030 Reset values of the outputs SHALL be: busy=0, done=0, out_valid=0, out_last=0, out_data=0, glb_address=0, glb_w_en=0.
REQ-031 Captured base_addr, word_count and stride SHALL reset to 0.

Configuration
REQ-032 Macro GLB_READER_STRIDE_EN:
- Defined: the stride input SHALL be honoured as specified.
- Undefined: the stride port SHALL remain present but be ignored, and the increment SHALL be fixed at 4 bytes.

Verification
REQ-033 Scenario "contiguous burst": base_addr=0x0100, word_count=4, stride=4, out_ready=1 -> addresses 0x0100/0x0104/0x0108/0x010C on consecutive cycles; 4 beats on consecutive cycles with out_last on beat 4; done one cycle after beat 4.
REQ-034 Scenario "backpressure": word_count=8, out_ready toggling 1,0,0,1... -> all 8 words delivered in order with none lost or duplicated, out_data stable while stalled, at most FIFO_DEPTH reads outstanding.
REQ-035 Scenario "zero count": word_count=0 -> done pulse 1 cycle after start, no out_valid, glb_address unchanged.
REQ-036 Scenario "address wrap": base_addr=0xFFF8, word_count=4, stride=4 -> addresses 0xFFF8, 0xFFFC, 0x0000, 0x0004.
REQ-037 Scenario "stride and reset": stride=16 with GLB_READER_STRIDE_EN defined -> addresses step by 0x10; with the macro undefined, addresses step by 4. Asserting rst after beat 2 -> next cycle IDLE with all outputs at reset values, and a new start is accepted normally.
